// File: rtl/rr_arbiter.sv
// Round-robin arbiter feeding a single registered output word with valid/ready handshake.
// Optional RR_ARBITER_LOCK_EN adds a per-requester lock input that holds ownership across transfers.
module rr_arbiter #(
   parameter  int unsigned REQ   = 4,
   parameter  int unsigned DATA  = 32,
   localparam int unsigned IDX_W = (REQ > 1) ? $clog2(REQ) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REQ-1:0]      req,
   input  logic [DATA*REQ-1:0] in,
`ifdef RR_ARBITER_LOCK_EN
   input  logic [REQ-1:0]      lock,
`endif
   output logic [REQ-1:0]      grant,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA-1:0]     out,
   output logic [IDX_W-1:0]    out_idx
);

   logic             out_valid_q, out_valid_d;
   logic [DATA-1:0]  out_q, out_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
`ifdef RR_ARBITER_LOCK_EN
   logic             locked_q, locked_d;
   logic [IDX_W-1:0] owner_q, owner_d;
`endif

   logic             load_c, found_hi_c, found_lo_c, grant_en_c;
   logic [IDX_W-1:0] win_hi_c, win_lo_c, win_c, ptr_next_c;
   logic [REQ-1:0]   elig_c;
   logic [DATA-1:0]  win_data_c;

   // Winner search: lowest eligible index at or above ptr, else lowest below ptr.
   always_comb begin
      load_c = !out_valid_q || out_ready;
      elig_c = req;
`ifdef RR_ARBITER_LOCK_EN
      for (int i = 0; i < int'(REQ); i++) begin
         if (locked_q && (IDX_W'(i) != owner_q)) elig_c[i] = 1'b0;
      end
`endif
      found_hi_c = 1'b0;
      found_lo_c = 1'b0;
      win_hi_c   = '0;
      win_lo_c   = '0;
      for (int i = int'(REQ) - 1; i >= 0; i--) begin
         if (elig_c[i]) begin
            if (IDX_W'(i) >= ptr_q) begin
               found_hi_c = 1'b1;
               win_hi_c   = IDX_W'(i);
            end else begin
               found_lo_c = 1'b1;
               win_lo_c   = IDX_W'(i);
            end
         end
      end
      win_c      = found_hi_c ? win_hi_c : win_lo_c;
      grant_en_c = load_c && (found_hi_c || found_lo_c) && !reset;
      ptr_next_c = (win_c == IDX_W'(REQ - 1)) ? '0 : win_c + IDX_W'(1);

      grant      = '0;
      win_data_c = '0;
      for (int i = 0; i < int'(REQ); i++) begin
         if (win_c == IDX_W'(i)) begin
            grant[i]   = grant_en_c;
            win_data_c = in[DATA*i +: DATA];
         end
      end
   end

   // Next-state: load on grant, drain on handshake, otherwise hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      out_idx_d   = out_idx_q;
      ptr_d       = ptr_q;
`ifdef RR_ARBITER_LOCK_EN
      locked_d    = locked_q;
      owner_d     = owner_q;
`endif
      if (grant_en_c) begin
         out_valid_d = 1'b1;
         out_d       = win_data_c;
         out_idx_d   = win_c;
         ptr_d       = ptr_next_c;
`ifdef RR_ARBITER_LOCK_EN
         // A locked grant keeps ptr parked so the owner stays first after release.
         if (|(lock & grant)) begin
            locked_d = 1'b1;
            owner_d  = win_c;
            ptr_d    = ptr_q;
         end else begin
            locked_d = 1'b0;
         end
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         out_idx_q   <= '0;
         ptr_q       <= '0;
`ifdef RR_ARBITER_LOCK_EN
         locked_q    <= 1'b0;
         owner_q     <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         out_idx_q   <= out_idx_d;
         ptr_q       <= ptr_d;
`ifdef RR_ARBITER_LOCK_EN
         locked_q    <= locked_d;
         owner_q     <= owner_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed vector bench for rr_arbiter (REQ=4, DATA=32, in[i]=i+1).
// Define RR_ARBITER_LOCK_EN for both files to exercise the lock feature.
module tb_rr_arbiter;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   req = '0;
   logic [3:0]   lock = '0;
   logic         out_ready = 1'b0;
   logic [127:0] in;
   logic [3:0]   grant;
   logic         out_valid;
   logic [31:0]  out;
   logic [1:0]   out_idx;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_arbiter #(.REQ(4), .DATA(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .in        (in),
`ifdef RR_ARBITER_LOCK_EN
      .lock      (lock),
`endif
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_idx   (out_idx)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  rq;
      logic [3:0]  lk;
      logic        rdy;
      logic [3:0]  g;
      logic        v;
      logic [31:0] o;
      logic [1:0]  idx;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [3:0] rq, logic [3:0] lk, logic rdy,
                               logic [3:0] g, logic v, logic [31:0] o, logic [1:0] idx);
      vec_t t;
      t.rst = rst; t.rq = rq; t.lk = lk; t.rdy = rdy;
      t.g = g; t.v = v; t.o = o; t.idx = idx;
      return t;
   endfunction

   task automatic check(string name, logic [3:0] g, logic v, logic [31:0] o, logic [1:0] idx);
      n_vec++;
      if (grant !== g || out_valid !== v || out !== o || out_idx !== idx) begin
         n_err++;
         $display("FAIL %s: got grant=%b valid=%b out=%0d idx=%0d, expected grant=%b valid=%b out=%0d idx=%0d",
                  name, grant, out_valid, out, out_idx, g, v, o, idx);
      end
   endtask

   task automatic run_table(string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         req       = vecs[i].rq;
         lock      = vecs[i].lk;
         out_ready = vecs[i].rdy;
         #1;
         check($sformatf("%s[%0d]", tag, i), vecs[i].g, vecs[i].v, vecs[i].o, vecs[i].idx);
      end
      vecs.delete();
   endtask

   initial begin
      bit seen;
      for (int i = 0; i < 4; i++) in[32*i +: 32] = 32'(i + 1);

      // Fields: rst, req, lock, ready | expected grant, valid, out, idx (state before the edge)
      vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));
      // round robin from ptr=0
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 1, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 2, 1));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 1, 3, 2));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 1, 4, 3));
      // single requester back-to-back
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 3, 2));
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 3, 2));
      // drain, then idle hold
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 3, 2));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3, 2));
      // wrap and skip from ptr=3
      vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 4'b0001, 0, 3, 2));
      vecs.push_back(mk(0, 4'b0101, 4'b0000, 1, 4'b0100, 1, 1, 0));
      // backpressure
      vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 4'b0001, 1, 3, 2));
      vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0000, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0000, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 4'b0010, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 1, 2, 1));
      // reset with a held word, then restart from ptr=0
      vecs.push_back(mk(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 1, 0));
      vecs.push_back(mk(0, 4'b1000, 4'b0000, 0, 4'b0000, 1, 1, 0));
      vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 4'b1000, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 4, 3));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4, 3));
      run_table("main");

      // Bounded wait for a load, then asynchronous reset in the middle of a clock phase
      @(negedge clk);
      req = 4'b0010;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = out_valid;
      end
      if (!seen) begin
         n_err++;
         $display("FAIL hs_timeout: got out_valid=0 after 5 cycles, expected 1");
      end
      check("hs_load", 4'b0010, 1, 2, 1);
      #2;
      reset = 1'b1;
      #1;
      check("hs_async_rst", 4'b0000, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      req = 4'b0000;

`ifdef RR_ARBITER_LOCK_EN
      vecs.push_back(mk(1, 4'b1111, 4'b0010, 1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 4'b0001, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 4'b0010, 1, 1, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 4'b0010, 1, 2, 1));
      vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 4'b0010, 1, 2, 1));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 2, 1));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 2, 1));
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 1, 3, 2));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 4, 3));
      run_table("lock");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
